dff8_tx_launch: RTL and testbench
=================================

// Module: dff8_tx_launch
// PURPOSE
//  Launch side of the 8-bit capture-register path. Buffers upstream bytes and drives them onto a
//  capture bus with a 1-cycle capture strobe. Each word is held stable SETUP_CYC cycles before the
//  strobe and HOLD_CYC cycles after it, so the receiving register's setup/hold checks never fire.
//  Sits between the byte producer and the dff8-style capture register.
// PARAMETERS
//  DW          8   data width of in_data / tx_data
//  SETUP_CYC   2   cycles tx_data is stable before tx_strobe (>=1)
//  HOLD_CYC    3   cycles tx_data is stable after tx_strobe (>=1)
//  FIFO_DEPTH  4   input buffer entries (power of 2, >=2)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  in_data    in   DW       upstream byte
//  in_valid   in   1        upstream word valid
//  in_ready   out  1        buffer can accept; push = in_valid & in_ready at posedge clk
//  tx_data    out  DW       launched word to capture register (registered)
//  tx_strobe  out  1        1-cycle capture enable for receiver (registered)
//  tx_busy    out  1        FSM not IDLE
//  tx_par     out  1        even parity of tx_data (only with DFF8_TX_PARITY_EN)
// BEHAVIOUR
//  Reset (async assert, sync release): tx_data=0, tx_strobe=0, tx_busy=0, tx_par=0, FIFO empty,
//   FSM=IDLE, counters=0. in_ready=0 while rst high. Reset mid-word aborts it; buffered words lost.
//  in_ready = !full (from current occupancy). No push bypass: when full, a same-cycle pop does not
//   allow a push that cycle.
//  FSM IDLE -> SETUP -> STROBE -> HOLD -> (SETUP | IDLE):
//   IDLE: if FIFO non-empty: pop head into tx_data, cnt=SETUP_CYC-1, -> SETUP.
//   SETUP: tx_data stable; cnt==0 -> STROBE, else cnt--.
//   STROBE: tx_strobe=1 exactly this one cycle; cnt=HOLD_CYC-1, -> HOLD.
//   HOLD: tx_data stable; at cnt==0: FIFO non-empty -> pop, load tx_data, -> SETUP (back-to-back);
//    else -> IDLE. Otherwise cnt--.
//  tx_data changes only on a pop edge; retains last word in IDLE (never returns to 0).
//  Latency: push at edge E0 into empty buffer/IDLE -> tx_data valid after E1 -> tx_strobe high in the
//   cycle after edge E1+SETUP_CYC. Strobe period back-to-back = SETUP_CYC+1+HOLD_CYC (6 default).
//  Push and pop same cycle: occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
//  tx_busy = (state != IDLE); registered state decode.
// CONFIGURATION
//  DFF8_TX_PARITY_EN defined: tx_par port present, registered even parity of the word, loaded on the
//   same edge as tx_data, reset 0. Not defined: port and logic absent; all else identical.
// STRUCTURE
//  Package dff8_tx_pkg: state enum (IDLE, SETUP, STROBE, HOLD), default DW/SETUP_CYC/HOLD_CYC/
//   FIFO_DEPTH constants, counter width function clog2-based.
//  Sub-module dff8_tx_fifo: DW x FIFO_DEPTH synchronous FIFO (push, pop, full, empty, head data);
//   top holds FSM, counter, output registers.
// TESTING
//  1 Reset: assert rst mid-STROBE -> tx_strobe=0, tx_data=0, tx_busy=0 same cycle; in_ready=0 during
//    rst, =1 one cycle after release; no further strobes.
//  2 Single word: push 8'hA5 at E0 -> tx_data=8'hA5 after E1; tx_strobe high only in cycle after E3;
//    tx_data stays 8'hA5 through HOLD and after; tx_busy low after E7.
//  3 Back-to-back: push 8'h01,8'h02,8'h03 on consecutive edges -> strobes exactly 6 cycles apart,
//    tx_data at each strobe = 01,02,03 in order, each stable 2 cycles before and 3 after strobe.
//  4 Full: hold in_valid with 6 words, no drain stalls -> in_ready drops after 4 buffered (+1 in
//    flight); no word lost or duplicated; order preserved over 20 random words.
//  5 Parity (DFF8_TX_PARITY_EN): send 8'h07 -> tx_par=1; 8'h03 -> tx_par=0, aligned with tx_data.
//  6 Timing: connect to capture register with $setup 2/$hold 3 checks -> zero violations over 100
//    random words; captured sequence equals pushed sequence.

Source files
------------

// File: rtl/dff8_tx_pkg.sv
// dff8_tx_pkg: shared state encoding, default sizes and counter width helper for the dff8 launch path
package dff8_tx_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;
  localparam int DEF_DW = 8;
  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_HOLD_CYC = 3;
  localparam int DEF_FIFO_DEPTH = 4;
  // Bits needed to count down from the longer of the setup/hold windows minus one.
  function automatic int cnt_w(input int setup_cyc, input int hold_cyc);
    int m;
    m = setup_cyc > hold_cyc ? setup_cyc : hold_cyc;
    return m > 2 ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/dff8_tx_fifo.sv
// dff8_tx_fifo: DW x DEPTH synchronous FIFO buffering upstream bytes ahead of the launch FSM
module dff8_tx_fifo #(
  parameter int DW = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout = mem[rd_q];
  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  // Pointer and occupancy registers; reset empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // Storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= din;
  end
endmodule

// File: rtl/dff8_tx_launch.sv
// dff8_tx_launch: launches buffered bytes with setup/hold-framed capture strobe; DFF8_TX_PARITY_EN adds tx_par
module dff8_tx_launch
  import dff8_tx_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] tx_data,
  output logic          tx_strobe,
  output logic          tx_busy
`ifdef DFF8_TX_PARITY_EN
  ,output logic         tx_par
`endif
);
  localparam int CW = cnt_w(SETUP_CYC, HOLD_CYC);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] data_q, data_d, head;
  logic strobe_q, strobe_d, busy_q, busy_d;
  logic push, pop, full, empty, cnt_z;
  assign in_ready = !rst && !full;
  assign push = in_valid && in_ready;
  assign tx_data = data_q;
  assign tx_strobe = strobe_q;
  assign tx_busy = busy_q;
  dff8_tx_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(in_data),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  // Next-state logic: a word is popped from IDLE or at the end of HOLD, so tx_data only moves on a pop.
  always_comb begin
    cnt_z = cnt_q == '0;
    pop = !empty && (state_q == IDLE || (state_q == HOLD && cnt_z));
    state_d = pop ? SETUP :
              (state_q == SETUP && cnt_z) ? STROBE :
              state_q == STROBE ? HOLD :
              (state_q == HOLD && cnt_z) ? IDLE : state_q;
    cnt_d = pop ? CW'(SETUP_CYC - 1) :
            state_q == STROBE ? CW'(HOLD_CYC - 1) :
            cnt_z ? cnt_q : cnt_q - CW'(1);
    data_d = pop ? head : data_q;
    strobe_d = state_d == STROBE;
    busy_d = state_d != IDLE;
  end
  // FSM, counter and registered outputs; reset aborts any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      data_q <= '0;
      strobe_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      strobe_q <= strobe_d;
      busy_q <= busy_d;
    end
  end
`ifdef DFF8_TX_PARITY_EN
  logic par_q, par_d;
  assign tx_par = par_q;
  // Even parity loaded on the same edge as the word it describes.
  always_comb par_d = pop ? ^head : par_q;
  // Parity register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else par_q <= par_d;
  end
`endif
endmodule

// File: tb/tb_dff8_tx_launch.sv
// tb_dff8_tx_launch: timeline-model bench for dff8_tx_launch (DFF8_TX_PARITY_EN enables parity checks)
module tb_dff8_tx_launch;
  localparam int N = 4096;
  logic clk = 0, rst = 1, in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready, tx_strobe, tx_busy;
  logic [7:0] tx_data;
`ifdef DFF8_TX_PARITY_EN
  logic tx_par;
`endif
  int checks = 0, failures = 0, cyc = 0, occ = 0, last_pop = -100;
  bit exp_pop[N], exp_dv[N], exp_strobe[N], exp_busy[N];
  bit [7:0] exp_data[N];
  bit [7:0] lastw = 0;
  bit [7:0] pushed[$], captured[$];
  int strobes[$];
  bit [7:0] sdata[$];

  always #5 clk = ~clk;

  dff8_tx_launch dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx_data(tx_data),
    .tx_strobe(tx_strobe),
    .tx_busy(tx_busy)
`ifdef DFF8_TX_PARITY_EN
    ,.tx_par(tx_par)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference timeline: each accepted word is popped at max(push+1, previous pop+6),
  // shown for 6 cycles from its pop edge, strobed 2 cycles after that edge.
  always @(posedge clk) begin
    cyc++;
    if (cyc > N - 20) begin
      $display("FAIL cycle_budget observed=%0d expected<%0d", cyc, N - 20);
      $fatal(1, "cycle budget exceeded");
    end
    if (!rst) begin
      if (exp_pop[cyc]) occ--;
      if (in_valid && in_ready) begin
        int p;
        p = (cyc + 1 > last_pop + 6) ? cyc + 1 : last_pop + 6;
        for (int k = 0; k < 6; k++) begin
          exp_dv[p+k] = 1;
          exp_data[p+k] = in_data;
          exp_busy[p+k] = 1;
        end
        exp_pop[p] = 1;
        exp_strobe[p+2] = 1;
        last_pop = p;
        occ++;
        pushed.push_back(in_data);
      end
    end
  end

  // Compare every cycle against the timeline, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_strobe", tx_strobe, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_busy", tx_busy, 0);
      chk("rst_ready", in_ready, 0);
    end else begin
      if (exp_dv[cyc]) lastw = exp_data[cyc];
      chk("strobe", tx_strobe, exp_strobe[cyc]);
      chk("data", tx_data, lastw);
      chk("busy", tx_busy, exp_busy[cyc]);
      chk("ready", in_ready, occ < 4);
`ifdef DFF8_TX_PARITY_EN
      chk("par", tx_par, ^lastw);
`endif
      if (tx_strobe) captured.push_back(tx_data);
    end
  end

  task automatic push_word(input logic [7:0] w);
    int n;
    n = 0;
    @(negedge clk);
    in_data = w;
    in_valid = 1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("push_timeout", n < 200, 1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic wait_strobe(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!tx_strobe && n < 40);
    chk(tag, tx_strobe, 1);
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    chk("t1_strobe", tx_strobe, 0);
    chk("t1_data", tx_data, 0);
    chk("t1_busy", tx_busy, 0);
    chk("t1_ready_low", in_ready, 0);
    for (int i = cyc; i < N; i++) begin
      exp_pop[i] = 0;
      exp_dv[i] = 0;
      exp_strobe[i] = 0;
      exp_busy[i] = 0;
    end
    occ = 0;
    last_pop = -100;
    lastw = 0;
    in_valid = 0;
    repeat (2) @(negedge clk);
    #2 rst = 0;
    @(posedge clk);
    #1 chk("t1_ready_high", in_ready, 1);
  endtask

  initial begin
    int e0, ns;
    repeat (2) @(negedge clk);
    #2 rst = 0;
    @(posedge clk);
    #1;
    chk("reset_ready", in_ready, 1);
    chk("reset_data", tx_data, 0);
    chk("reset_strobe", tx_strobe, 0);
    chk("reset_busy", tx_busy, 0);

    // Single word: strobe after E3, idle after E7, data retained.
    push_word(8'hA5);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      chk("t2_strobe", tx_strobe, k == 3);
      chk("t2_data", tx_data, 8'hA5);
      chk("t2_busy", tx_busy, k < 7);
    end

    // Back-to-back: strobes 6 cycles apart, in order.
    strobes.delete();
    sdata.delete();
    push_word(8'h01);
    e0 = cyc;
    push_word(8'h02);
    push_word(8'h03);
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1 if (tx_strobe) begin
        strobes.push_back(cyc);
        sdata.push_back(tx_data);
      end
    end
    chk("t3_count", strobes.size(), 3);
    if (strobes.size() == 3) begin
      chk("t3_first", strobes[0] - e0, 3);
      chk("t3_gap1", strobes[1] - strobes[0], 6);
      chk("t3_gap2", strobes[2] - strobes[1], 6);
      chk("t3_d0", sdata[0], 8'h01);
      chk("t3_d1", sdata[1], 8'h02);
      chk("t3_d2", sdata[2], 8'h03);
    end

    // Full buffer: 4 buffered + 1 in flight blocks the next push.
    for (int k = 0; k < 5; k++) push_word(8'($urandom));
    #1 chk("t4_full", in_ready, 0);
    for (int k = 0; k < 21; k++) push_word(8'($urandom));
    repeat (160) @(posedge clk);

`ifdef DFF8_TX_PARITY_EN
    push_word(8'h07);
    wait_strobe("t5_wait07");
    chk("t5_par07", tx_par, 1);
    chk("t5_data07", tx_data, 8'h07);
    push_word(8'h03);
    wait_strobe("t5_wait03");
    chk("t5_par03", tx_par, 0);
    chk("t5_data03", tx_data, 8'h03);
    repeat (10) @(posedge clk);
`endif

    // Reset mid-STROBE aborts the word and drops anything buffered.
    push_word(8'h5A);
    push_word(8'hC3);
    wait_strobe("t1_wait");
    #1 do_reset();
    ns = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1 if (tx_strobe) ns++;
    end
    chk("t1_no_strobe", ns, 0);

    // Random stream with random gaps: captured sequence equals pushed sequence.
    pushed.delete();
    captured.delete();
    for (int k = 0; k < 100; k++) begin
      repeat ($urandom_range(0, 8)) @(posedge clk);
      push_word(8'($urandom));
    end
    repeat (60) @(posedge clk);
    #1 chk("t6_count", captured.size(), pushed.size());
    for (int k = 0; k < pushed.size() && k < captured.size(); k++)
      chk("t6_word", captured[k], pushed[k]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
